// File: rtl/vip_flatten_pkg.sv
// Shared types and constants for the flatten-stage scheduler.
// Contents: FSM state encoding, default sizing constants, clog2 helper.
package vip_flatten_pkg;

  localparam int unsigned DEF_DWIDTH  = 32;
  localparam int unsigned DEF_NUM_CH  = 16;
  localparam int unsigned DEF_NUM_PIX = 784;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LATCH  = 3'd2,
    ST_SERIAL = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Ceiling log2, never below 1 so counters always have at least one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 31; i++) begin
      if (v > (32'd1 << i)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vip_flatten_word_mux.sv
// Shadow register for one pixel (all channel words) and channel word select.
// Ports:
//   clock, reset   : clock, async active-low reset
//   load           : capture din into the shadow this cycle
//   din            : packed channel words, channel k at [k*DWIDTH +: DWIDTH]
//   ch             : channel to select
//   word_c         : selected word (combinational)
module vip_flatten_word_mux #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned CH_W   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load,
  input  logic [NUM_CH*DWIDTH-1:0] din,
  input  logic [CH_W-1:0]          ch,
  output logic [DWIDTH-1:0]        word_c
);

  logic [NUM_CH*DWIDTH-1:0] shadow;
  logic [NUM_CH*DWIDTH-1:0] src_c;
  logic [31:0]              base_c;

  // Pixel shadow register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= din;
    end
  end

  // During the load cycle the shadow is not yet valid, so bypass the input
  assign src_c  = load ? din : shadow;
  assign base_c = 32'(ch) * DWIDTH;
  assign word_c = src_c[base_c +: DWIDTH];

endmodule

// File: rtl/vip_flatten_scheduler.sv
// Flatten-stage sequencer: pops one pixel from all channel FIFOs at once and
// writes the channel words one per cycle (channel 0 first) to the output FIFO.
// Optional macro VIP_FLATTEN_SKEW_CHK_EN adds the sticky skew_err output.
// Ports:
//   clock, reset   : clock, async active-low reset
//   start          : one-cycle pulse, begins one feature-map flatten
//   ff_rdata       : channel FIFO head words (show-ahead), channel k at [k*DWIDTH +: DWIDTH]
//   ff_empty       : per-channel empty flags
//   ff_rdreq       : shared pop to all channel FIFOs (registered)
//   ff_wdata       : output FIFO word (registered)
//   ff_wrreq       : output FIFO write strobe (registered)
//   ff_full        : output FIFO almost-full
//   busy, done     : dense-stage framing
//   skew_err       : lost-lockstep flag (macro builds only)
//   pix_cnt        : pixel currently being serialized
module vip_flatten_scheduler
  import vip_flatten_pkg::*;
#(
  parameter  int unsigned DWIDTH  = DEF_DWIDTH,
  parameter  int unsigned NUM_CH  = DEF_NUM_CH,
  parameter  int unsigned NUM_PIX = DEF_NUM_PIX,
  localparam int unsigned CH_W    = clog2(NUM_CH),
  localparam int unsigned PIX_W   = clog2(NUM_PIX)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_CH*DWIDTH-1:0] ff_rdata,
  input  logic [NUM_CH-1:0]        ff_empty,
  output logic                     ff_rdreq,
  output logic [DWIDTH-1:0]        ff_wdata,
  output logic                     ff_wrreq,
  input  logic                     ff_full,
  output logic                     busy,
  output logic                     done,
`ifdef VIP_FLATTEN_SKEW_CHK_EN
  output logic                     skew_err,
`endif
  output logic [PIX_W-1:0]         pix_cnt
);

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIX - 1);

  state_e             state, state_nxt;
  logic [CH_W-1:0]    ch, ch_nxt;
  logic               last_issued, last_issued_nxt;
  logic [PIX_W-1:0]   pix_cnt_nxt;
  logic               ff_rdreq_nxt, ff_wrreq_nxt, busy_nxt, done_nxt;
  logic [DWIDTH-1:0]  ff_wdata_nxt;
  logic               load_c, issue_c, all_ready_c;
  logic [DWIDTH-1:0]  word_c;

  assign all_ready_c = ~|ff_empty;
  assign load_c      = (state == ST_LATCH);

  vip_flatten_word_mux #(
    .DWIDTH (DWIDTH),
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_word_mux (
    .clock  (clock),
    .reset  (reset),
    .load   (load_c),
    .din    (ff_rdata),
    .ch     (ch),
    .word_c (word_c)
  );

  // State and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      ch          <= '0;
      last_issued <= 1'b0;
      pix_cnt     <= '0;
      ff_rdreq    <= 1'b0;
      ff_wrreq    <= 1'b0;
      ff_wdata    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      ch          <= ch_nxt;
      last_issued <= last_issued_nxt;
      pix_cnt     <= pix_cnt_nxt;
      ff_rdreq    <= ff_rdreq_nxt;
      ff_wrreq    <= ff_wrreq_nxt;
      ff_wdata    <= ff_wdata_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

  // Next state and next registered outputs. A word is "issued" into the
  // output register one cycle before it is presented with ff_wrreq; the pixel
  // ends in the cycle the last channel's word is presented.
  always_comb begin
    state_nxt       = state;
    ch_nxt          = ch;
    last_issued_nxt = last_issued;
    pix_cnt_nxt     = pix_cnt;
    ff_rdreq_nxt    = 1'b0;
    ff_wrreq_nxt    = 1'b0;
    ff_wdata_nxt    = ff_wdata;
    busy_nxt        = busy;
    done_nxt        = 1'b0;
    issue_c         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FETCH;
          busy_nxt  = 1'b1;
        end
      end
      ST_FETCH: begin
        if (all_ready_c) begin
          ff_rdreq_nxt = 1'b1;
          state_nxt    = ST_LATCH;
        end
      end
      ST_LATCH: begin
        issue_c   = 1'b1;
        state_nxt = ST_SERIAL;
      end
      ST_SERIAL: begin
        if (last_issued) begin
          last_issued_nxt = 1'b0;
          ch_nxt          = '0;
          if (pix_cnt == PIX_LAST) begin
            pix_cnt_nxt = '0;
            busy_nxt    = 1'b0;
            done_nxt    = 1'b1;
            state_nxt   = ST_DONE;
          end else begin
            pix_cnt_nxt = pix_cnt + PIX_W'(1);
            state_nxt   = ST_FETCH;
          end
        end else begin
          issue_c = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Under backpressure the pending word is still presented, without strobe
    if (issue_c) begin
      ff_wdata_nxt = word_c;
      if (!ff_full) begin
        ff_wrreq_nxt = 1'b1;
        ch_nxt       = ch + CH_W'(1);
        if (ch == CH_LAST) last_issued_nxt = 1'b1;
      end
    end
  end

`ifdef VIP_FLATTEN_SKEW_CHK_EN
  logic [1:0] skew_run;
  logic       skew_c;

  assign skew_c = (state == ST_FETCH) && (|ff_empty) && !(&ff_empty);

  // Partial-empty persisting 4 FETCH cycles means the channels lost lockstep
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      skew_run <= '0;
      skew_err <= 1'b0;
    end else if (skew_c) begin
      if (skew_run == 2'd3) skew_err <= 1'b1;
      else                  skew_run <= skew_run + 2'd1;
    end else begin
      skew_run <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_vip_flatten_scheduler.sv
// Self-checking bench for vip_flatten_scheduler with show-ahead channel FIFO
// model and an output-word scoreboard.
module tb_vip_flatten_scheduler;

  localparam int unsigned DWIDTH  = 32;
  localparam int unsigned NUM_CH  = 16;
  localparam int unsigned NUM_PIX = 784;
  localparam int unsigned PIX_W   = 10;

  logic                     clock, reset, start;
  logic [NUM_CH*DWIDTH-1:0] ff_rdata;
  logic [NUM_CH-1:0]        ff_empty, empty_mask;
  logic                     ff_rdreq, ff_wrreq, ff_full, busy, done;
  logic [DWIDTH-1:0]        ff_wdata;
  logic [PIX_W-1:0]         pix_cnt;
`ifdef VIP_FLATTEN_SKEW_CHK_EN
  logic                     skew_err;
`endif

  int  rd_ptr;
  logic refill;
  int  n_cmp    = 0;
  int  n_err    = 0;
  int  wr_cnt   = 0;
  int  done_cnt = 0;
  logic [DWIDTH-1:0] exp_q[$];

  vip_flatten_scheduler dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .ff_rdata (ff_rdata),
    .ff_empty (ff_empty),
    .ff_rdreq (ff_rdreq),
    .ff_wdata (ff_wdata),
    .ff_wrreq (ff_wrreq),
    .ff_full  (ff_full),
    .busy     (busy),
    .done     (done),
`ifdef VIP_FLATTEN_SKEW_CHK_EN
    .skew_err (skew_err),
`endif
    .pix_cnt  (pix_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [DWIDTH-1:0] word_of(input int p, input int k);
    return 32'h5A00_0000 ^ 32'(p << 8) ^ 32'(k);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Lockstep show-ahead channel FIFOs preloaded with NUM_PIX pixels
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ff_rdata[k*DWIDTH +: DWIDTH] = word_of(rd_ptr, k);
      ff_empty[k] = (rd_ptr >= int'(NUM_PIX)) | empty_mask[k];
    end
  end

  always @(posedge clock) begin
    if (refill)        rd_ptr <= 0;
    else if (ff_rdreq) rd_ptr <= rd_ptr + 1;
  end

  // Scoreboard: push on pop, compare on write
  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (ff_wrreq) begin
        wr_cnt++;
        if (exp_q.size() == 0) check_eq("wr_unexpected", ff_wrreq, 0);
        else                   check_eq("wdata", ff_wdata, exp_q.pop_front());
      end
      if (ff_rdreq) begin
        check_eq("rdreq_while_empty", 32'(|ff_empty), 0);
        for (int k = 0; k < NUM_CH; k++) exp_q.push_back(word_of(rd_ptr, k));
      end
      if (done) done_cnt++;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_word(input int p, input int k, input int budget, output logic hit);
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clock);
      if (ff_wrreq && ff_wdata == word_of(p, k)) hit = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget, output logic hit, output int cyc);
    hit = 1'b0;
    cyc = 0;
    while (cyc < budget && !hit) begin
      @(negedge clock);
      cyc++;
      if (done) hit = 1'b1;
    end
  endtask

  initial begin
    logic hit;
    int   cyc, wb, db;

    reset = 1'b0; start = 1'b0; ff_full = 1'b0; empty_mask = '0; refill = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("rst_rdreq", ff_rdreq, 0);
    check_eq("rst_wrreq", ff_wrreq, 0);
    check_eq("rst_wdata", ff_wdata, 0);
    check_eq("rst_busy",  busy, 0);
    check_eq("rst_done",  done, 0);
    check_eq("rst_pix",   pix_cnt, 0);
`ifdef VIP_FLATTEN_SKEW_CHK_EN
    check_eq("rst_skew", skew_err, 0);
`endif
    reset = 1'b1; refill = 1'b0;
    @(negedge clock);

    // Clean feature map: latency and total framing
    pulse_start();
    check_eq("a_busy_rise", busy, 1);
    check_eq("a_rdreq_c1", ff_rdreq, 0);
    cyc = 1; hit = 1'b0;
    while (cyc < 20000 && !hit) begin
      @(negedge clock);
      cyc++;
      if (cyc == 2) check_eq("a_rdreq_c2", ff_rdreq, 1);
      if (cyc == 3) begin
        check_eq("a_wrreq_c3", ff_wrreq, 1);
        check_eq("a_wdata_c3", ff_wdata, word_of(0, 0));
      end
      if (cyc == 18) check_eq("a_wdata_c18", ff_wdata, word_of(0, 15));
      if (cyc == 19) check_eq("a_pix_c19", pix_cnt, 1);
      if (done) hit = 1'b1;
    end
    check_eq("a_done_seen", hit, 1);
    check_eq("a_done_cycle", cyc, 14113);
    check_eq("a_busy_at_done", busy, 0);
    check_eq("a_pix_at_done", pix_cnt, 0);
    @(negedge clock);
    check_eq("a_done_width", done, 0);
    repeat (2) @(negedge clock);
    check_eq("a_words", wr_cnt, NUM_PIX * NUM_CH);
    check_eq("a_done_cnt", done_cnt, 1);

    // Backpressure, channel skew and a stray start in one feature map
    refill = 1'b1;
    @(negedge clock);
    refill = 1'b0;
    wb = wr_cnt; db = done_cnt;
    pulse_start();
    wait_word(1, 6, 200, hit);
    check_eq("b_found_ch6", hit, 1);
    ff_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check_eq("b_stall_wrreq", ff_wrreq, 0);
      check_eq("b_stall_wdata", ff_wdata, word_of(1, 7));
    end
    ff_full = 1'b0;
    @(negedge clock);
    check_eq("b_resume_wrreq", ff_wrreq, 1);
    check_eq("b_resume_ch7", ff_wdata, word_of(1, 7));
    @(negedge clock);
    check_eq("b_resume_ch8", ff_wdata, word_of(1, 8));
    pulse_start();
    wait_word(2, 15, 200, hit);
    check_eq("b_found_p2_ch15", hit, 1);
    empty_mask = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_eq("b_rdreq_skewed", ff_rdreq, 0);
    end
    empty_mask = '0;
`ifdef VIP_FLATTEN_SKEW_CHK_EN
    check_eq("b_skew_err", skew_err, 1);
`endif
    wait_done(20000, hit, cyc);
    check_eq("b_done_seen", hit, 1);
    repeat (40) @(negedge clock);
    check_eq("b_words", wr_cnt - wb, NUM_PIX * NUM_CH);
    check_eq("b_done_once", done_cnt - db, 1);
    check_eq("b_queue_empty", exp_q.size(), 0);
    check_eq("b_idle_busy", busy, 0);
`ifdef VIP_FLATTEN_SKEW_CHK_EN
    check_eq("b_skew_sticky", skew_err, 1);
`endif

    // Asynchronous reset mid-serialization, then restart
    refill = 1'b1;
    @(negedge clock);
    refill = 1'b0;
    pulse_start();
    hit = 1'b0; cyc = 0;
    while (cyc < 3000 && !hit) begin
      @(negedge clock);
      cyc++;
      if (pix_cnt == 100 && ff_wrreq) hit = 1'b1;
    end
    check_eq("c_reached_pix100", hit, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("c_rst_rdreq", ff_rdreq, 0);
    check_eq("c_rst_wrreq", ff_wrreq, 0);
    check_eq("c_rst_wdata", ff_wdata, 0);
    check_eq("c_rst_busy",  busy, 0);
    check_eq("c_rst_done",  done, 0);
    check_eq("c_rst_pix",   pix_cnt, 0);
`ifdef VIP_FLATTEN_SKEW_CHK_EN
    check_eq("c_rst_skew", skew_err, 0);
`endif
    refill = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1; refill = 1'b0;
    @(negedge clock);
    pulse_start();
    check_eq("c_pix_restart", pix_cnt, 0);
    @(negedge clock);
    check_eq("c_rdreq_c2", ff_rdreq, 1);
    @(negedge clock);
    check_eq("c_wrreq_c3", ff_wrreq, 1);
    check_eq("c_wdata_c3", ff_wdata, word_of(0, 0));
    repeat (20) @(negedge clock);
    check_eq("c_pix_next", pix_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
